// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder slice: FSM state encoding,
// the fixed request address bus width and the default data width.
package mem_pkg;

  // Width of the req_addr bus, independent of how many bits are decoded
  localparam int ADDR_BUS_W = 16;

  // Default data word width for the responder and its storage
  localparam int DEFAULT_DATA_W = 16;

  // Wait-state counter width; covers WAIT_CYC values 0..15
  localparam int CNT_W = 4;

  // Responder FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // True when every bit above the decoded address field is zero
  function automatic logic addr_in_range(input logic [ADDR_BUS_W-1:0] addr,
                                         input int addr_w);
    return (addr >> addr_w) == '0;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Storage for the memory responder: 2**ADDR_W words of DATA_W bits,
// written on the rising clock edge and read combinationally.
// Contents are deliberately not reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Synchronous write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts one request at a time on a valid/ready
// handshake, inserts WAIT_CYC wait states, then presents a response that
// is held until the initiator consumes it.
// Optional feature: define MEM_RESPONDER_RANGE_ERR_EN to flag accesses
// beyond the decoded depth with resp_err instead of wrapping the address.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int WAIT_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_BUS_W-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err
);

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic                  we_q;
  logic [ADDR_BUS_W-1:0] addr_q;
  logic [DATA_W-1:0]     wdata_q;

  logic                  acc_we;
  logic [ADDR_BUS_W-1:0] acc_addr;
  logic [DATA_W-1:0]     acc_wdata;
  logic                  accept;
  logic                  enter_resp;
  logic                  in_range;
  logic                  err_hit;
  logic                  mem_we;
  logic [DATA_W-1:0]     mem_rdata;
  logic [DATA_W-1:0]     rdata_next;

  assign accept = (state == IDLE) && req_valid;

  // With zero wait states the response is built on the acceptance edge
  // itself, so the live request fields are used before they are latched.
  always_comb begin
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    if (state == IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end
  end

  assign enter_resp = (accept && (WAIT_CYC == 0)) ||
                      ((state == WAIT) && (cnt == '0));

`ifdef MEM_RESPONDER_RANGE_ERR_EN
  assign in_range = addr_in_range(acc_addr, ADDR_W);
  assign err_hit  = ~in_range;
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^acc_addr;
  assign in_range = 1'b1;
  assign err_hit  = 1'b0;
`endif

  // The write commits exactly on the edge that enters RESP; an abort by
  // reset before that edge leaves the array untouched.
  assign mem_we     = enter_resp && acc_we && in_range;
  assign rdata_next = (acc_we || err_hit) ? '0 : mem_rdata;

  mem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .addr (acc_addr[ADDR_W-1:0]),
    .wdata(acc_wdata),
    .rdata(mem_rdata)
  );

  // Request/response FSM with registered handshake and response outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (WAIT_CYC == 0) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= rdata_next;
              resp_err   <= err_hit;
            end else begin
              state <= WAIT;
              cnt   <= CNT_W'(WAIT_CYC - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= rdata_next;
            resp_err   <= err_hit;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
